// File: rtl/sext_arb_pkg.sv
// Shared types and helpers for the sign-extension arbiter.
package sext_arb_pkg;

    typedef enum logic [1:0] {WSEL_Q1, WSEL_H, WSEL_Q3, WSEL_FULL} wsel_e;

    typedef enum logic {EMPTY, FULL} ostate_e;

    function automatic int field_width(wsel_e wsel, int data_w);
        case (wsel)
            WSEL_Q1: return data_w / 4;
            WSEL_H:  return data_w / 2;
            WSEL_Q3: return (3 * data_w) / 4;
            default: return data_w;
        endcase
    endfunction

endpackage

// File: rtl/sext_field_unit.sv
// Combinational field extender: low field chosen by wsel, sign or zero fill.
module sext_field_unit
    import sext_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  wsel_e             wsel,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] ext
);

    logic [DATA_W-1:0] cand [4];

    for (genvar k = 0; k < 4; k++) begin : g_ext
        localparam int F = field_width(wsel_e'(k), DATA_W);
        if (F < DATA_W) begin : g_part
            logic fill;
            assign fill     = is_unsigned ? 1'b0 : data[F-1];
            assign cand[k]  = {{(DATA_W-F){fill}}, data[F-1:0]};
        end else begin : g_full
            assign cand[k] = data;
        end
    end

    assign ext = cand[wsel];

endmodule

// File: rtl/sext_arbiter.sv
// Round-robin shared sign-extender with a one-entry output register.
// SEXT_ARB_ZERO_EXT_EN adds the per-requester req_unsigned zero-extend port.
module sext_arbiter
    import sext_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]      req_wsel,
`ifdef SEXT_ARB_ZERO_EXT_EN
    input  logic [NUM_REQ-1:0]        req_unsigned,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id
);

    ostate_e           state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gsel;
    logic              found;
    logic              can_load;
    logic              take;
    int                idx;
    logic [DATA_W-1:0] sel_data;
    wsel_e             sel_wsel;
    logic              sel_uns;
    logic [DATA_W-1:0] ext;

    // Search starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gsel  = ID_W'(idx);
            end
        end
    end

    assign can_load = (state == EMPTY) | out_ready;
    assign take     = found & can_load;

    always_comb begin
        req_ready       = '0;
        req_ready[gsel] = take;
    end

    assign sel_data = req_data[gsel*DATA_W +: DATA_W];
    assign sel_wsel = wsel_e'(req_wsel[gsel*2 +: 2]);
`ifdef SEXT_ARB_ZERO_EXT_EN
    assign sel_uns  = req_unsigned[gsel];
`else
    assign sel_uns  = 1'b0;
`endif

    sext_field_unit #(
        .DATA_W(DATA_W)
    ) u_field (
        .data       (sel_data),
        .wsel       (sel_wsel),
        .is_unsigned(sel_uns),
        .ext        (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (take) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= ext;
            out_id    <= gsel;
            rr_ptr    <= (gsel == ID_W'(NUM_REQ-1)) ? '0 : gsel + ID_W'(1);
        end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sext_arbiter.sv
// Directed and random checks of sext_arbiter against a behavioural model.
module tb_sext_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
`ifdef SEXT_ARB_ZERO_EXT_EN
    localparam bit ZEXT = 1'b1;
`else
    localparam bit ZEXT = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_data;
    logic [NR*2-1:0] req_wsel;
    logic [NR-1:0]   req_unsigned;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;

    int total = 0;
    int bad   = 0;

    // Reference state
    bit        m_valid;
    logic [31:0] m_data;
    int        m_id;
    int        m_ptr;

    sext_arbiter #(
        .NUM_REQ(NR),
        .DATA_W (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_wsel    (req_wsel),
`ifdef SEXT_ARB_ZERO_EXT_EN
        .req_unsigned(req_unsigned),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_ext(logic [31:0] d, int ws, bit uns);
        int f = 8 * (ws + 1);
        longint unsigned mask = (64'd1 << f) - 64'd1;
        longint unsigned v = {32'd0, d} & mask;
        if (!uns && d[f-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic int m_grant();
        for (int k = 0; k < NR; k++) begin
            int i = (m_ptr + k) % NR;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [31:0] d,
                           input int ws, input bit u);
        req_valid[i]        = v;
        req_data[i*DW +: DW] = d;
        req_wsel[i*2 +: 2]  = 2'(ws);
        req_unsigned[i]     = u;
    endtask

    // One clock: check handshake before the edge, outputs after it.
    task automatic cycle();
        int g;
        bit cl;
        logic [NR-1:0] er;
        #1;
        g  = m_grant();
        cl = !m_valid || out_ready;
        er = '0;
        if (g >= 0 && cl) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        #1;
        if (g >= 0 && cl) begin
            m_data  = m_ext(req_data[g*DW +: DW], int'(req_wsel[g*2 +: 2]),
                            ZEXT && req_unsigned[g]);
            m_id    = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % NR;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_id", 32'(out_id), 32'(m_id));
        end
    endtask

    initial begin
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        rst          = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        req_wsel     = '0;
        req_unsigned = '0;
        out_ready    = 1'b1;
        m_reset();
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single requester, quarter field
        set_req(0, 1, 32'h0000_0080, 0, 0);
        cycle();
        chk("t1_data", out_data, 32'hFFFF_FF80);
        chk("t1_id", 32'(out_id), 32'd0);
        set_req(0, 0, 0, 0, 0);
        cycle();

        set_req(2, 1, 32'hABCD_7FFF, 1, 0);
        cycle();
        chk("t2_half", out_data, 32'h0000_7FFF);
        chk("t2_id", 32'(out_id), 32'd2);
        set_req(2, 1, 32'h0080_0000, 2, 0);
        cycle();
        chk("t2_q3", out_data, 32'hFF80_0000);
        set_req(2, 0, 0, 0, 0);
        cycle();

        rst = 1'b1;
        #1 m_reset();
        rst = 1'b0;
        for (int i = 0; i < NR; i++)
            set_req(i, 1, 32'h1234_5600 + 32'(i), i, 0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t3_seq", 32'(out_id), 32'(seq[k]));
            chk("t3_valid", 32'(out_valid), 32'd1);
        end

        // Stall while full
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_hold_id", 32'(out_id), 32'd1);
            chk("t4_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("t4_resume", 32'(out_id), 32'd2);

        // Async reset during stall
        out_ready = 1'b0;
        cycle();
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_data", out_data, 32'd0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("t5_first", 32'(out_id), 32'd0);

        for (int i = 0; i < NR; i++) set_req(i, 0, 0, 0, 0);
        cycle();
        set_req(1, 1, 32'h0000_0080, 0, 1);
        cycle();
        chk("t6_uns", out_data, ZEXT ? 32'h0000_0080 : 32'hFFFF_FF80);
        set_req(1, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++)
                set_req(i, ($urandom_range(0, 99) < 55), $urandom,
                        $urandom_range(0, 3), 1'($urandom));
            out_ready = ($urandom_range(0, 99) < 65);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
